axi_read_master: RTL and testbench

- AXI4 read-only master that turns a simple word-address fetch request into one fixed-length INCR burst (cache-line fill).
- Sits on the master side of the AXI interconnect, e.g. behind the instruction-fetch path.
- Talks to slave-side wrappers such as the SRAM wrapper.
- Returns each beat to the requester as a registered one-cycle response pulse.

---
 rtl/axi_read_master.sv | 113 +++++++++++
 tb/tb_axi_read_master.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_master.sv
// AXI4 read master: one word-address fetch request becomes one fixed-length INCR burst; each beat returns as a registered pulse.
// Optional beat checking (RRESP, RID, RLAST position) is compiled in with AXI_RD_CHECK_EN.
module axi_read_master #(
  parameter logic [3:0] MASTER_ID = 4'd0,
  parameter int         BURST_LEN = 4
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_last,
  output logic        rsp_err,
  output logic [3:0]  ARID_M,
  output logic [31:0] ARADDR_M,
  output logic [3:0]  ARLEN_M,
  output logic [2:0]  ARSIZE_M,
  output logic [1:0]  ARBURST_M,
  output logic        ARVALID_M,
  input  logic        ARREADY_M,
  input  logic [3:0]  RID_M,
  input  logic [31:0] RDATA_M,
  input  logic [1:0]  RRESP_M,
  input  logic        RLAST_M,
  input  logic        RVALID_M,
  output logic        RREADY_M
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);

  state_t     state;
  logic [3:0] beat_cnt;
  logic       r_hs;
  logic       beat_err;

  assign ARID_M    = MASTER_ID;
  assign ARLEN_M   = LAST_BEAT;
  assign ARSIZE_M  = 3'b010;
  assign ARBURST_M = 2'b01;
  assign req_ready = (state == IDLE);
  assign r_hs      = RVALID_M & RREADY_M;

`ifdef AXI_RD_CHECK_EN
  // The counter only flags a misplaced RLAST; RLAST alone ends the burst.
  assign beat_err = (RRESP_M != 2'b00) || (RID_M != MASTER_ID) ||
                    ( RLAST_M && (beat_cnt != LAST_BEAT)) ||
                    (!RLAST_M && (beat_cnt == LAST_BEAT));
`else
  logic unused_chk;
  assign unused_chk = ^{RID_M, RRESP_M};
  assign beat_err   = 1'b0;
`endif

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state     <= IDLE;
      ARVALID_M <= 1'b0;
      RREADY_M  <= 1'b0;
      ARADDR_M  <= 32'h0;
      beat_cnt  <= 4'h0;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'h0;
      rsp_last  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            ARADDR_M  <= req_addr & 32'hFFFF_FFFC;
            ARVALID_M <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (ARREADY_M) begin
            ARVALID_M <= 1'b0;
            RREADY_M  <= 1'b1;
            beat_cnt  <= 4'h0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (r_hs) begin
            rsp_valid <= 1'b1;
            rsp_data  <= RDATA_M;
            rsp_last  <= RLAST_M;
            rsp_err   <= beat_err;
            if (beat_cnt != LAST_BEAT) begin
              beat_cnt <= beat_cnt + 4'h1;
            end
            if (RLAST_M) begin
              RREADY_M <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        default: begin
          ARVALID_M <= 1'b0;
          RREADY_M  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_master.sv
// Directed bench for axi_read_master: address phase, beat delivery, gaps, back-to-back, async reset, optional error flag.
module tb_axi_read_master;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        rsp_err;
  logic [3:0]  ARID_M;
  logic [31:0] ARADDR_M;
  logic [3:0]  ARLEN_M;
  logic [2:0]  ARSIZE_M;
  logic [1:0]  ARBURST_M;
  logic        ARVALID_M;
  logic        ARREADY_M = 1'b0;
  logic [3:0]  RID_M = 4'h0;
  logic [31:0] RDATA_M = 32'h0;
  logic [1:0]  RRESP_M = 2'b00;
  logic        RLAST_M = 1'b0;
  logic        RVALID_M = 1'b0;
  logic        RREADY_M;

  int checks = 0;
  int errors = 0;

  axi_read_master dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err),
    .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M), .ARSIZE_M(ARSIZE_M),
    .ARBURST_M(ARBURST_M), .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
    .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
    .RVALID_M(RVALID_M), .RREADY_M(RREADY_M)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  // Request from IDLE, hold ARREADY_M low for ar_wait cycles, then take the address.
  task automatic do_ar(input logic [31:0] addr, input logic [31:0] exp_addr, input int ar_wait);
    req_valid = 1'b1;
    req_addr  = addr;
    ARREADY_M = 1'b0;
    chk("req_ready_idle", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
    chk("arvalid_first", ARVALID_M, 1'b1);
    chk("araddr", ARADDR_M, exp_addr);
    chk("arlen", ARLEN_M, 4'd3);
    chk("arsize", ARSIZE_M, 3'b010);
    chk("arburst", ARBURST_M, 2'b01);
    chk("arid", ARID_M, 4'd0);
    chk("req_ready_busy", req_ready, 1'b0);
    for (int i = 0; i < ar_wait; i++) begin
      step();
      chk("arvalid_hold", ARVALID_M, 1'b1);
      chk("araddr_hold", ARADDR_M, exp_addr);
      chk("rsp_valid_addr", rsp_valid, 1'b0);
    end
    ARREADY_M = 1'b1;
    step();
    ARREADY_M = 1'b0;
    chk("arvalid_drop", ARVALID_M, 1'b0);
    chk("rready_data", RREADY_M, 1'b1);
  endtask

  // Drive RVALID_M per bit of vpat; RLAST_M on beat last_idx, SLVERR on beat bad_idx.
  // Ends at the sample point of the final response.
  task automatic do_data(input logic [15:0] vpat, input int ncyc, input int last_idx,
                         input int bad_idx, input logic [31:0] base);
    int  beat;
    bit  done;
    logic exp_err;
    beat = 0;
    done = 1'b0;
    for (int c = 0; c < ncyc && !done; c++) begin
      RVALID_M = vpat[c];
      RDATA_M  = base + 32'(beat);
      RLAST_M  = vpat[c] && (beat == last_idx);
      RRESP_M  = (vpat[c] && beat == bad_idx) ? 2'b10 : 2'b00;
      step();
      RVALID_M = 1'b0;
      RLAST_M  = 1'b0;
      RRESP_M  = 2'b00;
      chk("rsp_valid", rsp_valid, vpat[c]);
      if (vpat[c]) begin
`ifdef AXI_RD_CHECK_EN
        exp_err = (beat == bad_idx) || (beat == last_idx && last_idx != 3);
`else
        exp_err = 1'b0;
`endif
        chk("rsp_data", rsp_data, base + 32'(beat));
        chk("rsp_last", rsp_last, beat == last_idx);
        chk("rsp_err", rsp_err, exp_err);
        if (beat == last_idx) begin
          chk("req_ready_last", req_ready, 1'b1);
          chk("rready_end", RREADY_M, 1'b0);
          done = 1'b1;
        end
        beat++;
      end
    end
    chk("burst_done", done, 1'b1);
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst_arvalid", ARVALID_M, 1'b0);
    chk("rst_rready", RREADY_M, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_araddr", ARADDR_M, 32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    #3 ARESETn = 1'b1;
    step();

    // Basic burst, unaligned address, RVALID_M held high
    do_ar(32'h0000_1007, 32'h0000_1004, 0);
    do_data(16'h000F, 8, 3, -1, 32'hA0);
    step();
    chk("idle_no_rsp", rsp_valid, 1'b0);

    // ARREADY_M low for 3 cycles
    do_ar(32'h0000_2000, 32'h0000_2000, 3);
    do_data(16'h000F, 8, 3, -1, 32'hB0);
    step();

    // RVALID_M gaps 1,0,0,1,1,0,1
    do_ar(32'h0000_3000, 32'h0000_3000, 0);
    do_data(16'h0059, 10, 3, -1, 32'hC0);
    step();

    // SLVERR on beat 2
    do_ar(32'h0000_4000, 32'h0000_4000, 0);
    do_data(16'h000F, 8, 3, 1, 32'hD0);
    step();

    // Early RLAST on beat 3 of 4
    do_ar(32'h0000_5000, 32'h0000_5000, 0);
    do_data(16'h000F, 8, 2, -1, 32'hE0);
    step();
    chk("early_last_idle", req_ready, 1'b1);
    chk("early_last_rready", RREADY_M, 1'b0);

    // Back-to-back 0x100 then 0x200
    do_ar(32'h0000_0100, 32'h0000_0100, 0);
    do_data(16'h000F, 8, 3, -1, 32'h10);
    do_ar(32'h0000_0200, 32'h0000_0200, 0);
    do_data(16'h000F, 8, 3, -1, 32'h20);
    step();

    // Async reset mid-burst, with beat 2 pending on the bus
    do_ar(32'h0000_6000, 32'h0000_6000, 0);
    RVALID_M = 1'b1;
    RDATA_M  = 32'hF0;
    step();
    chk("pre_rst_rsp", rsp_valid, 1'b1);
    chk("pre_rst_data", rsp_data, 32'hF0);
    RDATA_M = 32'hF1;
    #2 ARESETn = 1'b0;
    #1;
    chk("arst_rsp_valid", rsp_valid, 1'b0);
    chk("arst_rsp_data", rsp_data, 32'h0);
    chk("arst_rready", RREADY_M, 1'b0);
    chk("arst_arvalid", ARVALID_M, 1'b0);
    chk("arst_araddr", ARADDR_M, 32'h0);
    RVALID_M = 1'b0;
    step();
    #3 ARESETn = 1'b1;
    step();
    chk("post_rst_rsp", rsp_valid, 1'b0);
    do_ar(32'h0000_7000, 32'h0000_7000, 0);
    do_data(16'h000F, 8, 3, -1, 32'h70);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
